// File: rtl/fifo_rd_packer_if.sv
// Bundles the FIFO read port and the packed-word output stream of fifo_rd_packer.
// The master modport is the packer; the slave modport is the FIFO plus downstream sink.
interface fifo_rd_packer_if #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 4,
    parameter int CNT_WIDTH = 3
);
    logic                   r_empty;
    logic [WIDTH-1:0]       r_data;
    logic                   destination_r_en;

    // Output stream: a word transfers on a cycle with m_valid & m_ready; while
    // m_valid is high and m_ready low, m_data and m_count hold their values.
    logic [WIDTH*LANES-1:0] m_data;
    logic [CNT_WIDTH-1:0]   m_count;
    logic                   m_valid;
    logic                   m_ready;

    modport master (
        input  r_empty, r_data, m_ready,
        output destination_r_en, m_data, m_count, m_valid
    );

    modport slave (
        output r_empty, r_data, m_ready,
        input  destination_r_en, m_data, m_count, m_valid
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops WIDTH-bit FIFO entries and packs LANES of them into one valid/ready output word.
// Define FIFO_RD_PACKER_FLUSH_EN to flush partial words after TIMEOUT idle cycles.
module fifo_rd_packer #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 4,
    parameter int CNT_WIDTH = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic                 r_clk,
    input  logic                 reset,
    fifo_rd_packer_if.master     bus,
    output logic [CNT_WIDTH-1:0] dbg_fill,
    output logic                 dbg_pending
);
    localparam logic [CNT_WIDTH:0]   LANES_X = (CNT_WIDTH+1)'(LANES);
    localparam logic [CNT_WIDTH-1:0] LANES_C = CNT_WIDTH'(LANES);

    logic [CNT_WIDTH-1:0]        fill_q, fill_d;
    logic                        pending_q, pending_d;
    logic [LANES-1:0][WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH*LANES-1:0]      m_data_q, m_data_d;
    logic [CNT_WIDTH-1:0]        m_count_q, m_count_d;
    logic                        m_valid_q, m_valid_d;

    logic rd_core;
    logic slot_free;
    logic full_go;
    logic flush_go;
    logic load;

    // Reads in flight count against free lanes so every popped entry has a slot.
    assign rd_core   = !bus.r_empty &&
                       (({1'b0, fill_q} + {{CNT_WIDTH{1'b0}}, pending_q}) < LANES_X);
    assign slot_free = !m_valid_q || bus.m_ready;
    assign full_go   = (fill_q == LANES_C) && slot_free;
    assign load      = full_go || flush_go;

`ifdef FIFO_RD_PACKER_FLUSH_EN
    localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] TIMEOUT_C = IDLE_W'(TIMEOUT);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // A partial word only goes out once it has been stranded with no read in flight.
    assign flush_go = (idle_q == TIMEOUT_C) && slot_free && !pending_q;

    always_comb begin
        idle_d = '0;
        if (!flush_go && (fill_q != '0) && (fill_q < LANES_C) && !pending_q && bus.r_empty) begin
            idle_d = (idle_q == TIMEOUT_C) ? idle_q : idle_q + 1'b1;
        end
    end

    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign flush_go       = 1'b0;
`endif

    always_comb begin
        acc_d     = acc_q;
        fill_d    = fill_q;
        m_data_d  = m_data_q;
        m_count_d = m_count_q;
        m_valid_d = m_valid_q;
        pending_d = rd_core;

        if (m_valid_q && bus.m_ready) begin
            m_valid_d = 1'b0;
        end

        if (pending_q) begin
            for (int i = 0; i < LANES; i++) begin
                if (fill_q == CNT_WIDTH'(i)) begin
                    acc_d[i] = bus.r_data;
                end
            end
            fill_d = fill_q + 1'b1;
        end

        // Lanes at or above fill are stale from an earlier word, so they are zeroed.
        if (load) begin
            for (int i = 0; i < LANES; i++) begin
                m_data_d[i*WIDTH +: WIDTH] = (CNT_WIDTH'(i) < fill_q) ? acc_q[i] : '0;
            end
            m_count_d = fill_q;
            m_valid_d = 1'b1;
            fill_d    = '0;
        end
    end

    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            fill_q    <= '0;
            pending_q <= 1'b0;
            acc_q     <= '0;
            m_data_q  <= '0;
            m_count_q <= '0;
            m_valid_q <= 1'b0;
        end else begin
            fill_q    <= fill_d;
            pending_q <= pending_d;
            acc_q     <= acc_d;
            m_data_q  <= m_data_d;
            m_count_q <= m_count_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign bus.destination_r_en = rd_core && !reset;
    assign bus.m_data           = m_data_q;
    assign bus.m_count          = m_count_q;
    assign bus.m_valid          = m_valid_q;
    assign dbg_fill             = fill_q;
    assign dbg_pending          = pending_q;
endmodule
